corr_snapshot_streamer: RTL



---
 rtl/corr_snapshot_streamer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/corr_snapshot_streamer.sv
// corr_snapshot_streamer
// Captures SNAPSHOT_LEN paired complex samples (channel A -> x, channel B -> y)
// from the ADC path into a local buffer, then replays them as a lock-stepped
// x/y stream with valid/last handshake to the correlation processor.
//
// Optional feature macro: STREAMER_CONJ_Y_EN
//   defined   : o_y_c carries the saturated negation of stored B imag (x * conj(y))
//   undefined : o_y_c carries stored B imag unchanged
module corr_snapshot_streamer #(
    parameter int DATA_WIDTH_BITS = 12,
    parameter int SNAPSHOT_LEN    = 256,
    parameter int ADDR_BITS       = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic                       i_adc_valid,
    input  logic [DATA_WIDTH_BITS-1:0] i_a_r,
    input  logic [DATA_WIDTH_BITS-1:0] i_a_c,
    input  logic [DATA_WIDTH_BITS-1:0] i_b_r,
    input  logic [DATA_WIDTH_BITS-1:0] i_b_c,
    input  logic                       i_ready_x,
    input  logic                       i_ready_y,
    output logic [DATA_WIDTH_BITS-1:0] o_x_r,
    output logic [DATA_WIDTH_BITS-1:0] o_x_c,
    output logic [DATA_WIDTH_BITS-1:0] o_y_r,
    output logic [DATA_WIDTH_BITS-1:0] o_y_c,
    output logic                       o_x_valid,
    output logic                       o_y_valid,
    output logic                       o_x_last,
    output logic                       o_y_last,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int ENTRY_W = 4 * DATA_WIDTH_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(SNAPSHOT_LEN - 1);
    localparam logic [DATA_WIDTH_BITS-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH_BITS-1){1'b0}}};
    localparam logic [DATA_WIDTH_BITS-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH_BITS-1){1'b1}}};

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        PRIME,
        STREAM,
        DONE
    } state_t;

    state_t state, next_state;

    logic [ENTRY_W-1:0]         buffer [SNAPSHOT_LEN];
    logic [ADDR_BITS-1:0]       wr_idx;
    logic [ADDR_BITS-1:0]       rd_idx;
    logic [ADDR_BITS-1:0]       rd_addr;
    logic [ENTRY_W-1:0]         rd_entry;
    logic [DATA_WIDTH_BITS-1:0] rd_a_r, rd_a_c, rd_b_r, rd_b_c;
    logic [DATA_WIDTH_BITS-1:0] y_c_load;

    logic beat_valid;
    logic beat_last;
    logic capture_wr;
    logic capture_end;
    logic xfer;
    logic xfer_last;

    // Saturating two's-complement negation; the most negative code has no
    // positive counterpart and clamps to the largest positive code.
    function automatic logic [DATA_WIDTH_BITS-1:0] neg_sat(input logic [DATA_WIDTH_BITS-1:0] v);
        if (v == MIN_VAL) begin
            return MAX_VAL;
        end
        return ~v + DATA_WIDTH_BITS'(1);
    endfunction

    assign capture_wr  = (state == CAPTURE) && i_adc_valid;
    assign capture_end = capture_wr && (wr_idx == LAST_IDX);
    assign xfer        = (state == STREAM) && beat_valid && i_ready_x && i_ready_y;
    assign xfer_last   = xfer && beat_last;

    // PRIME fetches entry 0; STREAM pre-fetches the entry after the current beat.
    assign rd_addr  = (state == PRIME) ? '0 : rd_idx + ADDR_BITS'(1);
    assign rd_entry = buffer[rd_addr];
    assign {rd_a_r, rd_a_c, rd_b_r, rd_b_c} = rd_entry;

`ifdef STREAMER_CONJ_Y_EN
    assign y_c_load = neg_sat(rd_b_c);
`else
    assign y_c_load = rd_b_c;
`endif

    // x and y share one handshake, so both valid/last pairs come from one register.
    assign o_x_valid = beat_valid;
    assign o_y_valid = beat_valid;
    assign o_x_last  = beat_last;
    assign o_y_last  = beat_last;

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        next_state = state;
        o_busy     = 1'b1;
        o_done     = 1'b0;
        unique case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (capture_end) begin
                    next_state = PRIME;
                end
            end
            PRIME: begin
                next_state = STREAM;
            end
            STREAM: begin
                if (xfer_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                o_done     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Capture write index: cleared on the accepted start, advanced per valid sample.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_idx <= '0;
        end else if ((state == IDLE) && i_start) begin
            wr_idx <= '0;
        end else if (capture_wr) begin
            wr_idx <= wr_idx + ADDR_BITS'(1);
        end
    end

    // Snapshot storage; contents are don't-care after reset, so no reset term.
    always_ff @(posedge i_clk) begin
        if (capture_wr) begin
            buffer[wr_idx] <= {i_a_r, i_a_c, i_b_r, i_b_c};
        end
    end

    // Output beat registers: load on PRIME and on each non-final transfer,
    // drop valid after the final transfer, otherwise hold.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rd_idx     <= '0;
            beat_valid <= 1'b0;
            beat_last  <= 1'b0;
            o_x_r      <= '0;
            o_x_c      <= '0;
            o_y_r      <= '0;
            o_y_c      <= '0;
        end else if (state == PRIME) begin
            rd_idx     <= '0;
            beat_valid <= 1'b1;
            beat_last  <= (SNAPSHOT_LEN == 1);
            o_x_r      <= rd_a_r;
            o_x_c      <= rd_a_c;
            o_y_r      <= rd_b_r;
            o_y_c      <= y_c_load;
        end else if (xfer_last) begin
            beat_valid <= 1'b0;
            beat_last  <= 1'b0;
        end else if (xfer) begin
            rd_idx     <= rd_addr;
            beat_last  <= (rd_addr == LAST_IDX);
            o_x_r      <= rd_a_r;
            o_x_c      <= rd_a_c;
            o_y_r      <= rd_b_r;
            o_y_c      <= y_c_load;
        end
    end

endmodule
